md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
Sequencer between the E-stage and the handshaked multi-cycle multiply/divide unit.
- Accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo requests and holds operands.
- Drives the unit's in/out valid-ready handshake.
- Owns the architectural HI/LO registers and raises the pipeline stall while the unit is occupied.
- Keeps exception-flushed requests from starting or writing state.

Parameters:
DATA_W, 32, operand and HI/LO width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low; 0 = reset asserted.
req_valid  in  1  E-stage holds an MD instruction.
req_op  in  4  MD op code (`MD_mult, `MD_multu, `MD_div, `MD_divu, `MD_mthi, `MD_mtlo, `MD_mfhi, `MD_mflo).
req_src0  in  DATA_W  rs value.
req_src1  in  DATA_W  rt value.
flush  in  1  exception/interrupt taken this cycle; E-stage request must not take effect.
req_ready  out  1  controller can accept a request.
stall  out  1  freeze F/D/E this cycle.
hi_out  out  DATA_W  architectural HI.
lo_out  out  DATA_W  architectural LO.
md_in_valid  out  1  operation offered to the unit.
md_in_ready  in  1  unit accepts the operation.
md_in_op  out  2  1 = multiply, 2 = divide.
md_in_sign  out  1  signed op.
md_src0  out  DATA_W  latched operand A.
md_src1  out  DATA_W  latched operand B.
md_out_valid  in  1  unit result available.
md_out_ready  out  1  controller takes the result.
md_res0  in  DATA_W  result low word (LO).
md_res1  in  DATA_W  result high word (HI).

Behaviour:
- Reset (async on reset=0):
  - state=IDLE; HI=LO=0; latched operands/op cleared.
  - Outputs: md_in_valid=0, md_out_ready=0, req_ready=1, stall=0.
  - Reset mid-ISSUE/BUSY abandons the op; HI/LO read 0.
- States:
  - IDLE: req_ready=1.
    - Start op (mult/multu/div/divu), req_valid=1, flush=0: latch src0/src1, md_in_op, md_in_sign (1 for mult/div); next ISSUE.
    - mthi/mtlo, req_valid=1, flush=0: write HI/LO at this edge; stay IDLE.
    - mfhi/mflo: no state change; hi_out/lo_out read directly.
    - Undefined op code: accepted as no-op.
  - ISSUE: md_in_valid=1; operands and op held stable.
    - On md_in_ready=1: next BUSY.
    - md_out_valid is ignored in ISSUE.
  - BUSY: md_out_ready=1.
    - On md_out_valid=1: LO<=md_res0, HI<=md_res1; next IDLE.
- Latency:
  - Accept at edge N; md_in_valid high in cycle N+1.
  - HI/LO visible the cycle after the out_valid edge; no bypass needed because mfhi/mflo are stalled until IDLE.
- req_ready = (state==IDLE).
- stall = req_valid & ~req_ready & ~flush. Any MD op, including mfhi/mflo/mthi/mtlo, waits while ISSUE/BUSY.
- flush:
  - Suppresses accept and writes only for the request presented in that cycle.
  - No effect on an op already in ISSUE/BUSY, which belongs to an older committed instruction; it completes and writes HI/LO.
- Divide by zero: no special case; the unit's result is written as returned.
- md_src0/md_src1 are registered outputs, never combinational from req_src*.

Decomposition:
- MD op codes (`MD_*) and state encodings go in the shared defines header Gobals.v.
- A small combinational sub-module md_op_decode (req_op -> is_start, is_mthi, is_mtlo, in_op, in_sign) is natural.
- FSM and HI/LO registers stay in md_issue_ctrl.

Test Plan:
1. Reset pulse (reset=0 for 2 cycles, mid-clock) -> immediately hi_out=lo_out=0, md_in_valid=0, req_ready=1, stall=0.
2. mult src0=0xFFFFFFFF, src1=0x00000002; unit returns res0=0xFFFFFFFE, res1=0xFFFFFFFF -> md_in_op=1, md_in_sign=1. An mflo issued during BUSY sees stall=1. The cycle after out_valid, lo_out=0xFFFFFFFE, hi_out=0xFFFFFFFF and stall drops.
3. mthi src0=0x00001234 in IDLE -> hi_out=0x00001234 next cycle. Repeat with src0=0xDEAD and flush=1 -> hi_out stays 0x00001234.
4. divu 100/7 with md_in_ready held low 3 cycles -> md_in_valid stays 1 with md_src0=100, md_src1=7 stable. res0=14, res1=2 written to LO/HI.
5. div issued, then flush=1 while BUSY -> result still written. A simultaneous mtlo carrying flush=1 is not applied.
6. Start multu, assert reset=0 mid-BUSY -> state IDLE, HI/LO=0, md_out_ready=0. A later out_valid pulse is ignored.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_issue_ctrl_pkg                                                |
// | MD op codes, controller state encodings and decode record type.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package md_issue_ctrl_pkg;

  localparam logic [3:0] c_MD_MULT  = 4'd0;
  localparam logic [3:0] c_MD_MULTU = 4'd1;
  localparam logic [3:0] c_MD_DIV   = 4'd2;
  localparam logic [3:0] c_MD_DIVU  = 4'd3;
  localparam logic [3:0] c_MD_MTHI  = 4'd4;
  localparam logic [3:0] c_MD_MTLO  = 4'd5;
  localparam logic [3:0] c_MD_MFHI  = 4'd6;
  localparam logic [3:0] c_MD_MFLO  = 4'd7;

  localparam logic [1:0] c_UNIT_NONE = 2'd0;
  localparam logic [1:0] c_UNIT_MUL  = 2'd1;
  localparam logic [1:0] c_UNIT_DIV  = 2'd2;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_BUSY  = 2'd2;

  typedef struct packed {
    logic       is_start;
    logic       is_mthi;
    logic       is_mtlo;
    logic [1:0] in_op;
    logic       in_sign;
  } md_dec_t;

endpackage
`default_nettype wire

// File: rtl/md_issue_ctrl_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_issue_ctrl_decode                                             |
// | Combinational MD op-code decode; unknown codes decode to no-op.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module md_issue_ctrl_decode
  import md_issue_ctrl_pkg::*;
(
  input  logic [3:0] i_op,
  output md_dec_t    o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_op)
      c_MD_MULT: begin
        o_dec.is_start = 1'b1;
        o_dec.in_op    = c_UNIT_MUL;
        o_dec.in_sign  = 1'b1;
      end
      c_MD_MULTU: begin
        o_dec.is_start = 1'b1;
        o_dec.in_op    = c_UNIT_MUL;
      end
      c_MD_DIV: begin
        o_dec.is_start = 1'b1;
        o_dec.in_op    = c_UNIT_DIV;
        o_dec.in_sign  = 1'b1;
      end
      c_MD_DIVU: begin
        o_dec.is_start = 1'b1;
        o_dec.in_op    = c_UNIT_DIV;
      end
      c_MD_MTHI: o_dec.is_mthi = 1'b1;
      c_MD_MTLO: o_dec.is_mtlo = 1'b1;
      default:   o_dec = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_issue_ctrl                                                    |
// | Sequences MD requests into the handshaked mul/div unit; owns HI/LO.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_src0,
  input  logic [DATA_W-1:0] req_src1,
  input  logic              flush,
  output logic              req_ready,
  output logic              stall,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              md_in_valid,
  input  logic              md_in_ready,
  output logic [1:0]        md_in_op,
  output logic              md_in_sign,
  output logic [DATA_W-1:0] md_src0,
  output logic [DATA_W-1:0] md_src1,
  input  logic              md_out_valid,
  output logic              md_out_ready,
  input  logic [DATA_W-1:0] md_res0,
  input  logic [DATA_W-1:0] md_res1
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  md_dec_t           w_dec;
  logic              w_take;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_src0;
  logic [DATA_W-1:0] r_src1;
  logic [1:0]        r_op;
  logic              r_sign;

  md_issue_ctrl_decode u_decode (
    .i_op  (req_op),
    .o_dec (w_dec)
  );

  // A flushed request never counts as taken, so it neither starts nor writes.
  assign w_take = req_valid & ~flush & (r_state == c_ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_take && w_dec.is_start) w_next = c_ST_ISSUE;
      c_ST_ISSUE: if (md_in_ready)              w_next = c_ST_BUSY;
      c_ST_BUSY:  if (md_out_valid)             w_next = c_ST_IDLE;
      default:                                  w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    md_in_valid  = 1'b0;
    md_out_ready = 1'b0;
    case (r_state)
      c_ST_IDLE:  req_ready    = 1'b1;
      c_ST_ISSUE: md_in_valid  = 1'b1;
      c_ST_BUSY:  md_out_ready = 1'b1;
      default:    req_ready    = 1'b0;
    endcase
  end

  assign stall = req_valid & ~req_ready & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_src0 <= '0;
      r_src1 <= '0;
      r_op   <= c_UNIT_NONE;
      r_sign <= 1'b0;
    end else if (w_take && w_dec.is_start) begin
      r_src0 <= req_src0;
      r_src1 <= req_src1;
      r_op   <= w_dec.in_op;
      r_sign <= w_dec.in_sign;
    end
  end

  // Unit results win over nothing: mthi/mtlo can only land while IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == c_ST_BUSY && md_out_valid) begin
      r_hi <= md_res1;
      r_lo <= md_res0;
    end else if (w_take) begin
      if (w_dec.is_mthi) r_hi <= req_src0;
      if (w_dec.is_mtlo) r_lo <= req_src0;
    end
  end

  assign hi_out     = r_hi;
  assign lo_out     = r_lo;
  assign md_src0    = r_src0;
  assign md_src1    = r_src1;
  assign md_in_op   = r_op;
  assign md_in_sign = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_md_issue_ctrl                                                 |
// | Directed plus randomized bench against an arithmetic HI/LO model.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_md_issue_ctrl;
  import md_issue_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src0;
  logic [31:0] req_src1;
  logic        flush;
  logic        req_ready;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        md_in_valid;
  logic        md_in_ready;
  logic [1:0]  md_in_op;
  logic        md_in_sign;
  logic [31:0] md_src0;
  logic [31:0] md_src1;
  logic        md_out_valid;
  logic        md_out_ready;
  logic [31:0] md_res0;
  logic [31:0] md_res1;

  int n_vec = 0;
  int n_err = 0;

  // Reference: an op is either waiting to be offered, or handed over and awaiting its result.
  bit          m_pend, m_wait;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [1:0]  m_op;
  bit          m_sign;

  md_issue_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_src0(req_src0), .req_src1(req_src1), .flush(flush),
    .req_ready(req_ready), .stall(stall), .hi_out(hi_out), .lo_out(lo_out),
    .md_in_valid(md_in_valid), .md_in_ready(md_in_ready), .md_in_op(md_in_op),
    .md_in_sign(md_in_sign), .md_src0(md_src0), .md_src1(md_src1),
    .md_out_valid(md_out_valid), .md_out_ready(md_out_ready),
    .md_res0(md_res0), .md_res1(md_res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural mul/div unit: {HI, LO} = {product high, product low} or {remainder, quotient}.
  function automatic logic [63:0] unit_result(input logic [1:0] op, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (op == 2'd1) begin
      p = 64'(sa * sb);
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = 64'(sa / sb);
    r = 64'(sa % sb);
    return {r[31:0], q[31:0]};
  endfunction

  task automatic model_clear();
    m_pend = 0; m_wait = 0; m_hi = '0; m_lo = '0;
    m_a = '0; m_b = '0; m_op = 2'd0; m_sign = 0;
  endtask

  // Drives one cycle of stimulus, checks at the falling edge, advances the model at the rising edge.
  task automatic step(input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit fl, input bit ir, input bit ov);
    logic [63:0] res;
    bit idle;
    res = unit_result(m_op, m_sign, m_a, m_b);
    req_valid = v; req_op = op; req_src0 = a; req_src1 = b; flush = fl;
    md_in_ready = ir; md_out_valid = ov;
    md_res0 = res[31:0]; md_res1 = res[63:32];
    @(negedge clk);
    idle = !m_pend && !m_wait;
    check("req_ready", req_ready, idle);
    check("stall", stall, v && !idle && !fl);
    check("md_in_valid", md_in_valid, m_pend);
    check("md_out_ready", md_out_ready, m_wait);
    check("hi_out", hi_out, m_hi);
    check("lo_out", lo_out, m_lo);
    if (m_pend) begin
      check("md_src0", md_src0, m_a);
      check("md_src1", md_src1, m_b);
      check("md_in_op", md_in_op, m_op);
      check("md_in_sign", md_in_sign, m_sign);
    end
    if (idle) begin
      if (v && !fl) begin
        if (op <= 4'd3) begin
          m_pend = 1; m_a = a; m_b = b;
          m_op   = (op == c_MD_MULT || op == c_MD_MULTU) ? 2'd1 : 2'd2;
          m_sign = (op == c_MD_MULT || op == c_MD_DIV);
        end else if (op == c_MD_MTHI) m_hi = a;
        else if (op == c_MD_MTLO) m_lo = a;
      end
    end else if (m_pend) begin
      if (ir) begin m_pend = 0; m_wait = 1; end
    end else if (ov) begin
      m_hi = res[63:32]; m_lo = res[31:0]; m_wait = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hi"}, hi_out, 0);
    check({tag, "_lo"}, lo_out, 0);
    check({tag, "_in_valid"}, md_in_valid, 0);
    check({tag, "_out_ready"}, md_out_ready, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_stall"}, stall, 0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; req_valid = 0; req_op = '0; req_src0 = '0; req_src1 = '0;
    flush = 0; md_in_ready = 0; md_out_valid = 0; md_res0 = '0; md_res1 = '0;
    model_clear();
    #3;
    pulse_reset("rst1");

    // Signed multiply, mflo stalled while BUSY.
    step(1, c_MD_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0, 0);
    check("t2_in_valid", md_in_valid, 1);
    check("t2_in_op", md_in_op, 2'd1);
    check("t2_in_sign", md_in_sign, 1);
    step(0, c_MD_MFLO, 0, 0, 0, 1, 0);
    step(1, c_MD_MFLO, 0, 0, 0, 0, 0);
    check("t2_busy_stall", stall, 1);
    step(1, c_MD_MFLO, 0, 0, 0, 0, 1);
    check("t2_lo", lo_out, 32'hFFFF_FFFE);
    check("t2_hi", hi_out, 32'hFFFF_FFFF);
    check("t2_stall_drop", stall, 0);

    // mthi, then a flushed mthi.
    step(1, c_MD_MTHI, 32'h1234, 0, 0, 0, 0);
    check("t3_hi", hi_out, 32'h1234);
    step(1, c_MD_MTHI, 32'hDEAD, 0, 1, 0, 0);
    check("t3_hi_flushed", hi_out, 32'h1234);

    // divu with in_ready withheld.
    step(1, c_MD_DIVU, 32'd100, 32'd7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_valid", md_in_valid, 1);
      check("t4_hold_src0", md_src0, 32'd100);
      check("t4_hold_src1", md_src1, 32'd7);
      step(0, c_MD_MFHI, 0, 0, 0, 0, 1);
    end
    step(0, c_MD_MFHI, 0, 0, 0, 1, 0);
    step(0, c_MD_MFHI, 0, 0, 0, 0, 1);
    check("t4_lo", lo_out, 32'd14);
    check("t4_hi", hi_out, 32'd2);

    // Flush while BUSY does not kill the older div; flushed mtlo is dropped.
    step(1, c_MD_DIV, 32'hFFFF_FFEC, 32'd3, 0, 0, 0);
    step(0, c_MD_MFHI, 0, 0, 0, 1, 0);
    step(1, c_MD_MTLO, 32'h5555, 0, 1, 0, 0);
    step(1, c_MD_MTLO, 32'h5555, 0, 1, 0, 1);
    check("t5_lo", lo_out, 32'hFFFF_FFFA);
    check("t5_hi", hi_out, 32'hFFFF_FFFE);
    step(1, c_MD_MTLO, 32'h5555, 0, 1, 0, 0);
    check("t5_lo_flushed", lo_out, 32'hFFFF_FFFA);

    // Reset mid-BUSY abandons the op; a stray out_valid is ignored.
    step(1, c_MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, c_MD_MFHI, 0, 0, 0, 1, 0);
    check("t6_busy", md_out_ready, 1);
    pulse_reset("t6_rst");
    step(0, c_MD_MFHI, 0, 0, 0, 0, 1);
    check("t6_hi", hi_out, 0);
    check("t6_lo", lo_out, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset("rand_rst");
      else step($urandom_range(0, 1), 4'($urandom_range(0, 15)), rand_word(), rand_word(),
                ($urandom_range(0, 6) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
